// File: rtl/bit_reverse_stream.sv
// bit_reverse_stream
//   Ping-pong reorder buffer for the FFT datapath. Samples arrive in natural
//   order, one per cycle, and each N = 2**LOG2N sample frame is replayed in
//   bit-reversed index order (or natural order if rev_en was low on the
//   frame's first sample). Two N-deep banks let one frame be written while
//   the previous one is read, so a continuous stream is sustained.
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   s_valid  input sample valid
//   s_ready  buffer can take a sample this cycle
//   s_data   input sample
//   rev_en   1 = bit-reversed readout, 0 = natural; captured with sample 0
//   flush    abandon the partially written input frame
//   m_valid  output sample valid
//   m_ready  downstream accepts the output sample
//   m_data   output sample
//   m_index  natural index of m_data within its frame
//   m_last   final sample of a frame
module bit_reverse_stream #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              rev_en,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LOG2N-1:0]  m_index,
  output logic              m_last
);

  localparam int N = 1 << LOG2N;
  // Index N-1 is all ones, which avoids any width juggling in compares.
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  logic [1:0]       full_reg;
  logic [1:0]       mode_reg;
  logic             wr_bank_reg;
  logic [LOG2N-1:0] wr_cnt_reg;
  logic             rd_bank_reg;
  logic [LOG2N-1:0] rd_cnt_reg;

  logic             wr_fire;
  logic             rd_fire;
  logic [LOG2N-1:0] rev_cnt;
  logic [LOG2N-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] bank_rd;

  assign s_ready = !full_reg[wr_bank_reg] && !flush;
  assign wr_fire = s_valid && s_ready;
  assign m_valid = full_reg[rd_bank_reg];
  assign rd_fire = m_valid && m_ready;

  // Bit reversal is pure wiring: output bit gi takes input bit LOG2N-1-gi.
  generate
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
      assign rev_cnt[gi] = rd_cnt_reg[LOG2N-1-gi];
    end
  endgenerate

  assign rd_addr = mode_reg[rd_bank_reg] ? rev_cnt : rd_cnt_reg;

  // Sample storage, one register file per bank. Each bank exposes the word
  // at rd_addr; the output mux below picks the bank being read.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] words [N];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) begin
            words[i] <= '0;
          end
        end else if (wr_fire && (wr_bank_reg == 1'(gi))) begin
          words[wr_cnt_reg] <= s_data;
        end
      end

      assign bank_rd[gi] = words[rd_addr];
    end
  endgenerate

  assign m_data  = bank_rd[rd_bank_reg];
  assign m_index = rd_addr;
  assign m_last  = m_valid && (rd_cnt_reg == LAST_IDX);

  // Write pointer, per-bank mode capture and the "bank filled" event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      mode_reg    <= '0;
    end else if (flush) begin
      wr_cnt_reg <= '0;
    end else if (wr_fire) begin
      if (wr_cnt_reg == '0) begin
        mode_reg[wr_bank_reg] <= rev_en;
      end
      if (wr_cnt_reg == LAST_IDX) begin
        wr_cnt_reg  <= '0;
        wr_bank_reg <= !wr_bank_reg;
      end else begin
        wr_cnt_reg <= wr_cnt_reg + LOG2N'(1);
      end
    end
  end

  // Read pointer. It only advances on a full bank, so it never trails into
  // a bank that the writer is still filling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_reg <= 1'b0;
      rd_cnt_reg  <= '0;
    end else if (rd_fire) begin
      if (rd_cnt_reg == LAST_IDX) begin
        rd_cnt_reg  <= '0;
        rd_bank_reg <= !rd_bank_reg;
      end else begin
        rd_cnt_reg <= rd_cnt_reg + LOG2N'(1);
      end
    end
  end

  // Full flags. The writer only sets a non-full bank and the reader only
  // clears a full bank, so the two updates always target different bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= '0;
    end else begin
      if (wr_fire && !flush && (wr_cnt_reg == LAST_IDX)) begin
        full_reg[wr_bank_reg] <= 1'b1;
      end
      if (rd_fire && (rd_cnt_reg == LAST_IDX)) begin
        full_reg[rd_bank_reg] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_reverse_stream.sv
module tb_bit_reverse_stream;

  localparam int DATA_W = 16;
  localparam int LOG2N  = 3;
  localparam int N      = 1 << LOG2N;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              rev_en = 1'b0;
  logic              flush = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [LOG2N-1:0]  m_index;
  logic              m_last;

  bit_reverse_stream #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .rev_en  (rev_en),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last)
  );

  always #5 clk = !clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit rand_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bit reversal of a frame index, computed arithmetically.
  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // A frame under construction plus a queue of every output still owed.
  int part_q[$];
  bit part_mode;
  int exp_data[$];
  int exp_idx[$];
  bit exp_last[$];
  int out_log[$];
  int out_cyc[$];

  always @(negedge clk) begin
    int frames;
    bit ready_m;
    if (rst) begin
      part_q.delete(); exp_data.delete(); exp_idx.delete(); exp_last.delete();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_index", m_index, 0);
      chk("rst_m_last", m_last, 0);
    end else begin
      frames  = (exp_data.size() + N - 1) / N;
      ready_m = (frames < 2) && !flush;
      chk("m_valid", m_valid, exp_data.size() > 0);
      chk("s_ready", s_ready, ready_m);
      if (exp_data.size() > 0) begin
        chk("m_data", m_data, exp_data[0]);
        chk("m_index", m_index, exp_idx[0]);
        chk("m_last", m_last, exp_last[0]);
      end else begin
        chk("m_last_idle", m_last, 0);
      end
      if (m_valid && m_ready) begin
        out_log.push_back(int'(m_data));
        out_cyc.push_back(cyc);
        $display("[TB] out data=%0d index=%0d last=%0d", m_data, m_index, m_last);
      end
      // Advance the model to what must hold after the coming edge.
      if (exp_data.size() > 0 && m_ready) begin
        void'(exp_data.pop_front()); void'(exp_idx.pop_front()); void'(exp_last.pop_front());
      end
      if (flush) begin
        part_q.delete();
      end else if (s_valid && ready_m) begin
        if (part_q.size() == 0) part_mode = rev_en;
        part_q.push_back(int'(s_data));
        if (part_q.size() == N) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = part_mode ? brev(k) : k;
            exp_data.push_back(part_q[idx]);
            exp_idx.push_back(idx);
            exp_last.push_back(k == N - 1);
          end
          part_q.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit r);
    bit a = 1'b0;
    int k = 0;
    s_valid = 1'b1;
    s_data  = d[DATA_W-1:0];
    rev_en  = r;
    while (!a && k < 1000) begin
      @(negedge clk);
      a = s_ready;
      tick();
      k++;
    end
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (out_log.size() < n && k < 2000) begin
      tick();
      k++;
    end
    chk("wait_out_count", out_log.size(), n);
  endtask

  task automatic check_log(input string name, input int req[], input int base);
    for (int i = 0; i < req.size(); i++) begin
      if (base + i < out_log.size()) chk(name, out_log[base + i], req[i]);
      else chk({name, "_missing"}, -1, req[i]);
    end
  endtask

  int t1[]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int t2[]  = '{10, 11, 12, 13, 14, 15, 16, 17, 20, 24, 22, 26, 21, 25, 23, 27};
  int t5[]  = '{100, 104, 102, 106, 101, 105, 103, 107};
  int t6[]  = '{40, 44, 42, 46, 41, 45, 43, 47};

  initial begin
    int c_acc;
    int c_raise;
    int req[];

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Test 1: one reversed frame 0..7, output one cycle after last accept.
    m_ready = 1'b1;
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < N; i++) send(i, 1'b1);
    c_acc = cyc;
    s_valid = 1'b0;
    wait_out(N);
    check_log("t1_data", t1, 0);
    if (out_cyc.size() > 0) chk("t1_latency", out_cyc[0], c_acc);

    // Test 2: natural frame then reversed frame, streamed back to back.
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < N; i++) send(10 + i, 1'b0);
    for (int i = 0; i < N; i++) send(20 + i, 1'b1);
    s_valid = 1'b0;
    wait_out(2 * N);
    check_log("t2_data", t2, 0);
    if (out_cyc.size() == 2 * N) chk("t2_no_idle", out_cyc[2 * N - 1] - out_cyc[0], 2 * N - 1);

    // Test 3: backpressure with both banks full.
    m_ready = 1'b0;
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < 2 * N; i++) send(i, 1'b1);
    s_valid = 1'b1;
    s_data  = 16'd16;
    tick(); tick();
    @(negedge clk);
    chk("t3_s_ready_low", s_ready, 0);
    tick();
    m_ready = 1'b1;
    c_raise = cyc;
    send(16, 1'b1);
    chk("t3_resume_cycle", cyc - c_raise, N + 1);
    for (int i = 17; i < 3 * N; i++) send(i, 1'b1);
    s_valid = 1'b0;
    wait_out(3 * N);
    req = new[3 * N];
    foreach (req[i]) req[i] = (i / N) * N + brev(i % N);
    check_log("t3_data", req, 0);

    // Test 4: random downstream stalls over 20 frames, alternating mode.
    out_log.delete(); out_cyc.delete();
    rand_en = 1'b1;
    for (int i = 0; i < 20 * N; i++) send(1000 + i, 1'((i / N) % 2));
    s_valid = 1'b0;
    wait_out(20 * N);
    rand_en = 1'b0;
    tick();
    m_ready = 1'b1;
    req = new[20 * N];
    foreach (req[i]) req[i] = 1000 + (i / N) * N + (((i / N) % 2) ? brev(i % N) : i % N);
    check_log("t4_data", req, 0);

    // Test 5: flush a 3-sample partial frame.
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < 3; i++) send(50 + i, 1'b1);
    s_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < N; i++) send(100 + i, 1'b1);
    s_valid = 1'b0;
    wait_out(N);
    repeat (4) tick();
    chk("t5_count", out_log.size(), N);
    check_log("t5_data", t5, 0);

    // Test 6: reset while a frame is half read out.
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) send(30 + i, 1'b0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("t6_m_valid_async", m_valid, 0);
    chk("t6_s_ready_async", s_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < N; i++) send(40 + i, 1'b1);
    s_valid = 1'b0;
    wait_out(N);
    check_log("t6_data", t6, 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bit_reverse_stream.md
Name: bit_reverse_stream

Overview:
- Streaming, parametrised bit-reversal reorder buffer for the FFT datapath.
- Accepts one sample per cycle in natural order on a valid/ready input and emits each N-sample frame in bit-reversed index order (or natural order when reversal is disabled) on a valid/ready output.
- Ping-pong double buffering sustains 1 sample/cycle between the sample source and the butterfly stages.

Parameters:
- DATA_W, 16, sample width in bits.
- LOG2N, 2, log2 of frame length; N = 2^LOG2N; legal range 1..6.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  input sample valid.
- s_ready  output  1  block can accept an input sample this cycle.
- s_data  input  DATA_W  input sample.
- rev_en  input  1  1 = bit-reversed output order, 0 = natural order; sampled with the first sample of each frame.
- flush  input  1  synchronous abort of the partially written input frame.
- m_valid  output  1  output sample valid.
- m_ready  input  1  downstream accepts output sample.
- m_data  output  DATA_W  output sample.
- m_index  output  LOG2N  original (natural) index of m_data within its frame.
- m_last  output  1  high on the final sample of a frame.

Behaviour:
- Storage: two banks, each N x DATA_W flops. Per-bank full flag and per-bank captured mode bit. Write pointer state: wr_bank, wr_cnt. Read pointer state: rd_bank, rd_cnt.
- Reset (async):
  - wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0.
  - Both full flags = 0, both mode bits = 0, all storage = 0.
  - Resulting outputs: m_valid = 0, m_last = 0, m_index = 0, m_data = 0, s_ready = 1.
  - Reset mid-frame discards all buffered data; no partial output.
- Write side:
  - s_ready = !full[wr_bank] && !flush.
  - On s_valid && s_ready: bank[wr_bank][wr_cnt] <= s_data. If wr_cnt == 0, also mode[wr_bank] <= rev_en.
  - If wr_cnt == N-1: full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0. Otherwise wr_cnt increments.
- Flush:
  - When flush = 1: wr_cnt <= 0 and the write is blocked (s_ready = 0 in that cycle).
  - Full banks and the read side are unaffected.
  - Flush with wr_cnt == 0 is a no-op.
- Read side:
  - m_valid = full[rd_bank].
  - rd_addr = mode[rd_bank] ? bitrev(rd_cnt) : rd_cnt, where bitrev reverses the LOG2N bits.
  - m_data = bank[rd_bank][rd_addr] (mux from registered storage; no additional pipeline stage).
  - m_index = rd_addr.
  - m_last = m_valid && (rd_cnt == N-1).
  - m_data, m_index and m_last hold their values while m_valid && !m_ready.
  - On m_valid && m_ready: if rd_cnt == N-1, then full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0; otherwise rd_cnt increments.
- Latency: the edge that accepts sample N-1 of a frame sets full. m_valid = 1 in the following cycle, with the first reordered sample present. Output index 0 is always emitted first.
- Throughput: with m_ready held at 1 and s_valid continuous, s_ready never drops; one frame in and one frame out every N cycles after the initial N-cycle fill.
- Simultaneous events:
  - Write completing into one bank and read completing from the other bank in the same cycle are both honoured.
  - A write can only set a non-full bank and a read can only clear a full bank, so same-bank set/clear cannot coincide.
- Backpressure: with both banks full, s_ready = 0 until the read side frees a bank. s_ready rises in the cycle after the edge that clears full[wr_bank].
- rev_en changes mid-frame have no effect on the frame being written.

Test Plan:
- LOG2N=3, rev_en=1, write 0..7 with m_ready=1 -> one cycle after the 8th accept, m_data sequence 0,4,2,6,1,5,3,7 on consecutive cycles; m_last only on 7; m_index equals m_data.
- LOG2N=2 default, rev_en=0 then a second frame with rev_en=1, inputs 10..13 then 20..23 -> outputs 10,11,12,13 then 20,22,21,23, streamed with no idle cycles.
- LOG2N=3, m_ready=0, 16 continuous inputs plus a 17th offered -> s_ready drops after the 16th accept. Set m_ready=1 -> s_ready returns one cycle after the 8th output; no data lost or duplicated.
- Random m_ready toggling over 20 frames with continuous input -> output equals the bit-reversal permutation per frame; m_data/m_index stable during every stall.
- LOG2N=3, write 3 samples, pulse flush, then write 8 samples 100..107 -> output 100,104,102,106,101,105,103,107; the three flushed samples are never emitted.
- Assert rst while a frame is half read out -> m_valid = 0 and s_ready = 1 immediately. The next full frame is emitted correctly from index 0.
